// File: rtl/arb_pkg.sv
// arb_pkg: shared types and helpers for the round-robin lock arbiter.
package arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_t;

    function automatic int onehot2idx(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++)
            if (oh[i]) idx |= i;
        return idx;
    endfunction

endpackage

// File: rtl/lsb_onehot.sv
// lsb_onehot: isolates the lowest set bit of x as a one-hot vector (zero in, zero out).
module lsb_onehot #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);
    assign y = x & ~(x - W'(1));
endmodule

// File: rtl/rr_lock_arb.sv
// rr_lock_arb: round-robin arbiter whose registered grant stays with its owner
// until the owner drops req or MAX_HOLD cycles elapse.
module rr_lock_arb
    import arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_vld,
    output logic [IDW-1:0] gnt_id,
    output logic           hold_timeout
);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    arb_state_t     state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d, mask_q, mask_d;
    logic           gnt_vld_q, gnt_vld_d, hold_timeout_q, hold_timeout_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [N-1:0]   win_masked, win_any, win;
    logic           owner_req, limit_hit;

    lsb_onehot #(.W(N)) u_lsb_masked (.x(req & mask_q), .y(win_masked));
    lsb_onehot #(.W(N)) u_lsb_any    (.x(req),          .y(win_any));

    always_comb begin
        win            = (|win_masked) ? win_masked : win_any;
        owner_req      = req[gnt_id_q];
        limit_hit      = (MAX_HOLD != 0) && (hold_cnt_q == HW'(MAX_HOLD - 1));
        state_d        = state_q;
        gnt_d          = gnt_q;
        gnt_vld_d      = gnt_vld_q;
        gnt_id_d       = gnt_id_q;
        mask_d         = mask_q;
        hold_cnt_d     = hold_cnt_q;
        hold_timeout_d = 1'b0;
        if (state_q == ARB_IDLE) begin
            if (|req) begin
                state_d    = ARB_OWNED;
                gnt_d      = win;
                gnt_vld_d  = 1'b1;
                gnt_id_d   = IDW'(onehot2idx(32'(win)));
                hold_cnt_d = '0;
            end
        end else if (!owner_req || limit_hit) begin
            // Next search starts strictly above the releasing owner; owner N-1 wraps to an empty mask.
            state_d        = ARB_IDLE;
            gnt_d          = '0;
            gnt_vld_d      = 1'b0;
            mask_d         = ~((gnt_q << 1) - N'(1));
            hold_timeout_d = owner_req;
        end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ARB_IDLE;
            gnt_q          <= '0;
            gnt_vld_q      <= 1'b0;
            gnt_id_q       <= '0;
            mask_q         <= '1;
            hold_cnt_q     <= '0;
            hold_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            gnt_vld_q      <= gnt_vld_d;
            gnt_id_q       <= gnt_id_d;
            mask_q         <= mask_d;
            hold_cnt_q     <= hold_cnt_d;
            hold_timeout_q <= hold_timeout_d;
        end
    end

    assign gnt          = gnt_q;
    assign gnt_vld      = gnt_vld_q;
    assign gnt_id       = gnt_id_q;
    assign hold_timeout = hold_timeout_q;

endmodule

// File: tb/tb_rr_lock_arb.sv
// tb_rr_lock_arb: table vectors, directed corner sequences and random traffic
// checked against an owner/pointer reference model.
module tb_rr_lock_arb;
    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic       clk, rst_n;
    logic [3:0] req, gnt;
    logic       gnt_vld, hold_timeout;
    logic [1:0] gnt_id;

    int tests = 0;
    int fails = 0;

    rr_lock_arb #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
        .gnt_vld(gnt_vld), .gnt_id(gnt_id), .hold_timeout(hold_timeout)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Reference: owner index (-1 idle), search start pointer, cycles held.
    int m_owner, m_last, m_ptr, m_held;
    bit m_to;

    function automatic void m_reset();
        m_owner = -1;
        m_last  = 0;
        m_ptr   = 0;
        m_held  = 0;
        m_to    = 0;
    endfunction

    function automatic void m_step(input logic [3:0] r);
        int w;
        w    = -1;
        m_to = 0;
        if (m_owner < 0) begin
            if (r != 0) begin
                for (int i = m_ptr; i < N; i++) if (w < 0 && r[i]) w = i;
                for (int i = 0; i < N; i++) if (w < 0 && r[i]) w = i;
                m_owner = w;
                m_last  = w;
                m_held  = 1;
            end
        end else if (!r[m_owner] || m_held == MAX_HOLD) begin
            m_to    = r[m_owner];
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else begin
            m_held++;
        end
    endfunction

    function automatic logic [7:0] m_out();
        logic [3:0] g;
        g = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
        return {g, m_owner >= 0, 2'(m_last), m_to};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        m_step(r);
        #1;
        check("model", {24'b0, gnt, gnt_vld, gnt_id, hold_timeout}, {24'b0, m_out()});
    endtask

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] gnt;
        logic       vld;
        logic [1:0] id;
        logic       to;
    } vec_t;

    vec_t vt[12];
    int   to_cnt;

    initial begin
        vt[0]  = '{4'b0001, 4'b0001, 1, 0, 0};
        vt[1]  = '{4'b0001, 4'b0001, 1, 0, 0};
        vt[2]  = '{4'b0001, 4'b0001, 1, 0, 0};
        vt[3]  = '{4'b0000, 4'b0000, 0, 0, 0};
        vt[4]  = '{4'b0011, 4'b0010, 1, 1, 0};
        vt[5]  = '{4'b0001, 4'b0000, 0, 1, 0};
        vt[6]  = '{4'b1001, 4'b1000, 1, 3, 0};
        vt[7]  = '{4'b0000, 4'b0000, 0, 3, 0};
        vt[8]  = '{4'b0101, 4'b0001, 1, 0, 0};
        vt[9]  = '{4'b0100, 4'b0000, 0, 0, 0};
        vt[10] = '{4'b0110, 4'b0010, 1, 1, 0};
        vt[11] = '{4'b0000, 4'b0000, 0, 1, 0};

        rst_n = 0;
        req   = 0;
        m_reset();
        #3;
        check("reset", {24'b0, gnt, gnt_vld, gnt_id, hold_timeout}, 32'h0);
        #9 rst_n = 1;

        for (int i = 0; i < 12; i++) begin
            req = vt[i].req;
            @(posedge clk);
            m_step(vt[i].req);
            #1;
            check($sformatf("vec%0d", i), {24'b0, gnt, gnt_vld, gnt_id, hold_timeout},
                  {24'b0, vt[i].gnt, vt[i].vld, vt[i].id, vt[i].to});
        end

        // Timeout: two requesters held constant alternate with 8-cycle tenures.
        to_cnt = 0;
        for (int k = 1; k <= 19; k++) begin
            step(4'b0011);
            to_cnt += int'(hold_timeout);
            if (k == 8)  check("to_own0_end", {28'b0, gnt}, 32'b0001);
            if (k == 9)  check("to_pulse0", {28'b0, gnt, 1'b0} | 32'(hold_timeout), 32'b1);
            if (k == 10) check("to_own1", {28'b0, gnt}, 32'b0010);
            if (k == 19) check("to_back0", {28'b0, gnt}, 32'b0001);
        end
        check("to_pulses", 32'(to_cnt), 32'd2);

        // Reset mid-grant clears outputs without waiting for a clock edge.
        step(4'b0100);
        step(4'b0100);
        check("own2", {28'b0, gnt}, 32'b0100);
        #2 rst_n = 0;
        #1;
        check("async_rst", {24'b0, gnt, gnt_vld, gnt_id, hold_timeout}, 32'h0);
        #2 rst_n = 1;
        m_reset();
        step(4'b1010);
        check("post_rst", {26'b0, gnt, gnt_id}, {26'b0, 4'b0010, 2'd1});

        // Non-owner noise must not disturb owner 1.
        for (int k = 1; k <= 8; k++) begin
            step({k[0], 1'b0, 1'b1, k[0]});
            if (k < 8) check("noise_hold", {27'b0, gnt, hold_timeout}, {27'b0, 4'b0010, 1'b0});
            else       check("noise_to", {27'b0, gnt, hold_timeout}, {27'b0, 4'b0000, 1'b1});
        end

        for (int k = 0; k < 400; k++) begin
            step({$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0});
            if (k % 16 == 0) check("vld_inv", 32'(gnt_vld), 32'(|gnt));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
